// File: rtl/pe_mac_acc_if.sv
// Operand, accumulator and drain-chain signals of one systolic PE.
// slave is the PE side, master is the driver/neighbour side.
interface pe_mac_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              signed_mode;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              drain_load;
    logic              drain_shift;
    logic [ACC_W-1:0]  drain_in;

    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              out_valid;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  mac_count;
    logic              ovf;
    logic [ACC_W-1:0]  drain_out;

    modport slave (
        input  in_valid, signed_mode, a_in, b_in, drain_load, drain_shift, drain_in,
        output a_out, b_out, out_valid, acc, mac_count, ovf, drain_out
    );

    modport master (
        output in_valid, signed_mode, a_in, b_in, drain_load, drain_shift, drain_in,
        input  a_out, b_out, out_valid, acc, mac_count, ovf, drain_out
    );
endinterface

// File: rtl/pe_mac_acc.sv
// Systolic MAC processing element with sticky overflow and a double-buffered drain chain.
// Optional: define PE_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module pe_mac_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    pe_mac_acc_if.slave    bus
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = ACC_W + 2;

    logic [DATA_W-1:0] a_q, b_q;
    logic              valid_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  drain_q;

    logic signed [DATA_W:0] a_x, b_x;
    logic signed [PW-1:0]   prod;
    logic signed [SW-1:0]   prod_x, base_x, sum;
    logic                   ovf_now;
    logic [ACC_W-1:0]       acc_next;
    logic [CNT_W-1:0]       cnt_next;

    // One extra bit lets a single signed multiplier serve both modes exactly.
    assign a_x  = {bus.signed_mode & bus.a_in[DATA_W-1], bus.a_in};
    assign b_x  = {bus.signed_mode & bus.b_in[DATA_W-1], bus.b_in};
    assign prod = a_x * b_x;

    assign prod_x = {{(SW-PW){bus.signed_mode & prod[PW-1]}}, prod};
    assign base_x = bus.drain_load ? '0
                  : {{2{bus.signed_mode & acc_q[ACC_W-1]}}, acc_q};
    assign sum    = base_x + (bus.in_valid ? prod_x : '0);

    // The two guard bits hold the ideal sum, so range checks are on the top bits only.
    assign ovf_now = bus.signed_mode
                   ? !((&sum[SW-1:ACC_W-1]) || (~|sum[SW-1:ACC_W-1]))
                   : (|sum[SW-1:ACC_W]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_next = sum[ACC_W-1:0];
`ifdef PE_SATURATE_EN
        if (ovf_now) begin
            if (!bus.signed_mode)
                acc_next = '1;
            else if (sum[SW-1])
                acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            else
                acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        cnt_next = cnt_q;
        if (bus.drain_load)
            cnt_next = {{(CNT_W-1){1'b0}}, bus.in_valid};
        else if (bus.in_valid && cnt_q != '1)
            cnt_next = cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            drain_q <= '0;
        end else begin
            if (bus.drain_load)
                drain_q <= acc_q;
            else if (bus.drain_shift)
                drain_q <= bus.drain_in;

            if (clear) begin
                a_q     <= '0;
                b_q     <= '0;
                valid_q <= 1'b0;
                acc_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (bus.in_valid) begin
                    a_q <= bus.a_in;
                    b_q <= bus.b_in;
                end
                valid_q <= bus.in_valid;
                acc_q   <= acc_next;
                cnt_q   <= cnt_next;
                ovf_q   <= bus.drain_load ? ovf_now : (ovf_q | ovf_now);
            end
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.out_valid = valid_q;
    assign bus.acc       = acc_q;
    assign bus.mac_count = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.drain_out = drain_q;
endmodule

// File: tb/tb_pe_mac_acc.sv
// Bench for pe_mac_acc: a 20-bit and a 16-bit PE share stimulus and are compared every
// cycle against an arithmetic model, plus hand-computed expectations.
module tb_pe_mac_acc;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int AW16 = 16;
    localparam int CW = 8;
`ifdef PE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    pe_mac_acc_if #(.DATA_W(DW), .ACC_W(AW),   .CNT_W(CW)) ifc ();
    pe_mac_acc_if #(.DATA_W(DW), .ACC_W(AW16), .CNT_W(CW)) ifc16 ();

    pe_mac_acc #(.DATA_W(DW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifc.slave)
    );
    pe_mac_acc #(.DATA_W(DW), .ACC_W(AW16), .CNT_W(CW)) dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifc16.slave)
    );

    assign ifc16.in_valid    = ifc.in_valid;
    assign ifc16.signed_mode = ifc.signed_mode;
    assign ifc16.a_in        = ifc.a_in;
    assign ifc16.b_in        = ifc.b_in;
    assign ifc16.drain_load  = ifc.drain_load;
    assign ifc16.drain_shift = ifc.drain_shift;
    assign ifc16.drain_in    = ifc.drain_in[AW16-1:0];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model state; index 0 is the 20-bit PE, index 1 the 16-bit PE.
    longint    m_acc [2];
    longint    m_drain [2];
    bit        m_ovf [2];
    logic [7:0] m_a, m_b;
    bit        m_v;
    int        m_cnt;

    task automatic model_step();
        longint sa, sb, prod, base, sum, lo, hi, mask, res, old;
        int w;
        bit ov;
        bit sm;
        sm = ifc.signed_mode;
        sa = sm ? longint'($signed(ifc.a_in)) : longint'(ifc.a_in);
        sb = sm ? longint'($signed(ifc.b_in)) : longint'(ifc.b_in);
        prod = sa * sb;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? AW : AW16;
            mask = (64'sd1 <<< w) - 1;
            old = m_acc[k];
            if (ifc.drain_load) m_drain[k] = old;
            else if (ifc.drain_shift) m_drain[k] = longint'(ifc.drain_in) & mask;
            if (clear) begin
                m_acc[k] = 0;
                m_ovf[k] = 1'b0;
            end else begin
                base = ifc.drain_load ? 0 : ((sm && old[w-1]) ? old - (64'sd1 <<< w) : old);
                sum = base + (ifc.in_valid ? prod : 0);
                lo = sm ? -(64'sd1 <<< (w - 1)) : 0;
                hi = sm ? (64'sd1 <<< (w - 1)) - 1 : mask;
                ov = (sum < lo) || (sum > hi);
                res = (SAT && ov) ? ((sum < lo) ? lo : hi) : sum;
                m_acc[k] = res & mask;
                m_ovf[k] = ifc.drain_load ? ov : (m_ovf[k] | ov);
            end
        end
        if (clear) begin
            m_a = '0; m_b = '0; m_v = 1'b0; m_cnt = 0;
        end else begin
            if (ifc.in_valid) begin
                m_a = ifc.a_in;
                m_b = ifc.b_in;
            end
            m_v = ifc.in_valid;
            if (ifc.drain_load) m_cnt = ifc.in_valid ? 1 : 0;
            else if (ifc.in_valid && m_cnt < 255) m_cnt = m_cnt + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_drain[k] = 0; m_ovf[k] = 1'b0;
            end
            m_a = '0; m_b = '0; m_v = 1'b0; m_cnt = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("a_out",       64'(ifc.a_out),       64'(m_a));
            check("b_out",       64'(ifc.b_out),       64'(m_b));
            check("out_valid",   64'(ifc.out_valid),   64'(m_v));
            check("mac_count",   64'(ifc.mac_count),   64'(m_cnt));
            check("acc",         64'(ifc.acc),         m_acc[0]);
            check("ovf",         64'(ifc.ovf),         64'(m_ovf[0]));
            check("drain_out",   64'(ifc.drain_out),   m_drain[0]);
            check("acc16",       64'(ifc16.acc),       m_acc[1]);
            check("ovf16",       64'(ifc16.ovf),       64'(m_ovf[1]));
            check("drain_out16", 64'(ifc16.drain_out), m_drain[1]);
            check("mac_count16", 64'(ifc16.mac_count), 64'(m_cnt));
        end
    end

    task automatic step(input bit c, input bit v, input bit sm,
                        input logic [7:0] a, input logic [7:0] b,
                        input bit dl = 1'b0, input bit ds = 1'b0,
                        input logic [19:0] din = 20'h0);
        clear = c;
        ifc.in_valid = v;
        ifc.signed_mode = sm;
        ifc.a_in = a;
        ifc.b_in = b;
        ifc.drain_load = dl;
        ifc.drain_shift = ds;
        ifc.drain_in = din;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick_operand();
        logic [7:0] edges [4];
        edges[0] = 8'h80; edges[1] = 8'h7F; edges[2] = 8'hFF; edges[3] = 8'h00;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    initial begin
        bit sm_r;
        int r;
        ifc.in_valid = 1'b0; ifc.signed_mode = 1'b0; ifc.a_in = '0; ifc.b_in = '0;
        ifc.drain_load = 1'b0; ifc.drain_shift = 1'b0; ifc.drain_in = '0;
        #3;
        check("rst_acc",       64'(ifc.acc),       64'h0);
        check("rst_out_valid", 64'(ifc.out_valid), 64'h0);
        check("rst_drain",     64'(ifc.drain_out), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Signed MACs: -3*5 + 7*-2 = -29
        step(1, 0, 1, 8'h00, 8'h00);
        step(0, 1, 1, 8'hFD, 8'h05);
        step(0, 1, 1, 8'h07, 8'hFE);
        check("sgn_acc",       64'(ifc.acc),       64'hFFFE3);
        check("sgn_count",     64'(ifc.mac_count), 64'd2);
        check("sgn_a_out",     64'(ifc.a_out),     64'h07);
        check("sgn_out_valid", 64'(ifc.out_valid), 64'h1);
        step(0, 0, 1, 8'h00, 8'h00);
        check("idle_out_valid", 64'(ifc.out_valid), 64'h0);
        check("idle_a_hold",    64'(ifc.a_out),     64'h07);

        // 0xFF*0xFF in each mode
        step(1, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'hFF, 8'hFF);
        check("uns_ff", 64'(ifc.acc), 64'd65025);
        step(1, 0, 1, 8'h00, 8'h00);
        step(0, 1, 1, 8'hFF, 8'hFF);
        check("sgn_ff", 64'(ifc.acc), 64'd1);

        // Drain handoff
        step(1, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'd10, 8'd10);
        step(0, 1, 0, 8'd2, 8'd3, 1'b1, 1'b0);
        check("dl_drain", 64'(ifc.drain_out), 64'd100);
        check("dl_acc",   64'(ifc.acc),       64'd6);
        check("dl_count", 64'(ifc.mac_count), 64'd1);
        step(0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b1, 20'h12345);
        check("ds_drain",   64'(ifc.drain_out),   64'h12345);
        check("ds_drain16", 64'(ifc16.drain_out), 64'h2345);
        check("ds_acc",     64'(ifc.acc),         64'd6);

        // Overflow on the 16-bit PE: 3 * 127*127 = 48387
        step(1, 0, 1, 8'h00, 8'h00);
        repeat (3) step(0, 1, 1, 8'h7F, 8'h7F);
        check("ovf16_acc", 64'(ifc16.acc), SAT ? 64'h7FFF : 64'hBD03);
        check("ovf16_flag", 64'(ifc16.ovf), 64'h1);
        check("ovf20_acc",  64'(ifc.acc),   64'd48387);
        check("ovf20_flag", 64'(ifc.ovf),   64'h0);
        step(0, 0, 1, 8'h00, 8'h00, 1'b1, 1'b0);
        check("ovf16_after_dl", 64'(ifc16.ovf), 64'h0);

        // clear + drain_load + in_valid together
        step(1, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 8'd5, 8'd10);
        step(1, 1, 0, 8'd4, 8'd4, 1'b1, 1'b0);
        check("cd_drain",     64'(ifc.drain_out), 64'd50);
        check("cd_acc",       64'(ifc.acc),       64'h0);
        check("cd_a_out",     64'(ifc.a_out),     64'h0);
        check("cd_out_valid", 64'(ifc.out_valid), 64'h0);
        check("cd_count",     64'(ifc.mac_count), 64'h0);

        // Asynchronous reset mid-accumulation
        repeat (3) step(0, 1, 1, pick_operand(), pick_operand(), 1'b0, 1'b1, 20'($urandom));
        #2 rst_n = 1'b0;
        #1;
        check("ar_acc",       64'(ifc.acc),       64'h0);
        check("ar_a_out",     64'(ifc.a_out),     64'h0);
        check("ar_b_out",     64'(ifc.b_out),     64'h0);
        check("ar_out_valid", 64'(ifc.out_valid), 64'h0);
        check("ar_count",     64'(ifc.mac_count), 64'h0);
        check("ar_ovf",       64'(ifc.ovf),       64'h0);
        check("ar_drain",     64'(ifc.drain_out), 64'h0);
        rst_n = 1'b1;

        // Long run: counter saturation and 20-bit overflow
        step(1, 0, 1, 8'h00, 8'h00);
        repeat (260) step(0, 1, 1, 8'h7F, 8'($urandom_range(100, 127)));
        check("cnt_sat", 64'(ifc.mac_count), 64'd255);
        check("ovf20_long", 64'(ifc.ovf), 64'h1);

        // Randomised traffic
        sm_r = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            bit c, dl;
            r = int'($urandom_range(0, 99));
            c = (r < 2);
            dl = (r >= 2 && r < 5);
            if (c || dl) sm_r = 1'($urandom_range(0, 1));
            step(c, $urandom_range(0, 3) != 0, sm_r, pick_operand(), pick_operand(),
                 dl, $urandom_range(0, 3) == 0, 20'($urandom));
        end

        step(0, 0, sm_r, 8'h00, 8'h00);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
